// File: rtl/regfile_pkg.sv
// Shared types and constants for the register file initiator.
package regfile_pkg;

  localparam int REG_ZERO = 0;
  localparam int REG_LAST = 31;

  typedef enum logic [1:0] {
    OP_READ2 = 2'd0,
    OP_WRITE = 2'd1,
    OP_COPY  = 2'd2,
    OP_CLEAR = 2'd3
  } cmd_op_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_WR    = 3'd2,
    S_CP_RD = 3'd3,
    S_CP_WR = 3'd4,
    S_CLR   = 3'd5,
    S_RESP  = 3'd6
  } state_t;

endpackage

// File: rtl/regfile_initiator.sv
// Command-driven initiator: sequences one host command at a time onto the register
// file read/write pins and returns the result on a response channel.
module regfile_initiator
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_src0,
  input  logic [ADDR_WIDTH-1:0] cmd_src1,
  input  logic [ADDR_WIDTH-1:0] cmd_dst,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data0,
  output logic [DATA_WIDTH-1:0] rsp_data1,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] regReadSel0,
  output logic [ADDR_WIDTH-1:0] regReadSel1,
  output logic [ADDR_WIDTH-1:0] regWriteSel,
  output logic                  writeEnable,
  output logic [DATA_WIDTH-1:0] writeData,
  input  logic [DATA_WIDTH-1:0] regReadData0,
  input  logic [DATA_WIDTH-1:0] regReadData1,
  output logic [2:0]            dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};

  state_t                  state, state_nx;
  logic                    armed;
  logic [ADDR_WIDTH-1:0]   src0_q, src1_q, dst_q, clr_cnt;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    accept;
  logic                    reject;

  // Both channels: a transfer happens on a rising edge where valid and ready are both
  // high; the sender keeps its payload stable while valid is high and ready is low.
  assign accept    = cmd_valid & armed & (state == S_IDLE);
  assign cmd_ready = armed & (state == S_IDLE);
  assign reject    = ((cmd_op_t'(cmd_op) == OP_WRITE) || (cmd_op_t'(cmd_op) == OP_COPY)) &&
                     (cmd_dst == ADDR_WIDTH'(REG_ZERO));
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    rsp_valid   = 1'b0;
    regReadSel0 = '0;
    regReadSel1 = '0;
    regWriteSel = '0;
    writeEnable = 1'b0;
    writeData   = '0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (reject) state_nx = S_RESP;
          else begin
            case (cmd_op_t'(cmd_op))
              OP_READ2: state_nx = S_RD;
              OP_WRITE: state_nx = S_WR;
              OP_COPY:  state_nx = S_CP_RD;
              default:  state_nx = S_CLR;
            endcase
          end
        end
      end
      S_RD: begin
        regReadSel0 = src0_q;
        regReadSel1 = src1_q;
        state_nx    = S_RESP;
      end
      S_WR: begin
        regWriteSel = dst_q;
        writeData   = data_q;
        writeEnable = 1'b1;
        state_nx    = S_RESP;
      end
      S_CP_RD: begin
        regReadSel0 = src0_q;
        state_nx    = S_CP_WR;
      end
      S_CP_WR: begin
        regWriteSel = dst_q;
        writeData   = rsp_data0;
        writeEnable = 1'b1;
        state_nx    = S_RESP;
      end
      S_CLR: begin
        regWriteSel = clr_cnt;
        writeEnable = 1'b1;
        if (clr_cnt == LAST_IDX) state_nx = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Command latches and response registers; the read-capture states load the
  // combinational register file data on the edge that leaves them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed     <= 1'b0;
      src0_q    <= '0;
      src1_q    <= '0;
      dst_q     <= '0;
      data_q    <= '0;
      clr_cnt   <= '0;
      rsp_data0 <= '0;
      rsp_data1 <= '0;
      rsp_err   <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        src0_q    <= cmd_src0;
        src1_q    <= cmd_src1;
        dst_q     <= cmd_dst;
        data_q    <= cmd_data;
        clr_cnt   <= ADDR_WIDTH'(1);
        rsp_data0 <= '0;
        rsp_data1 <= '0;
        rsp_err   <= reject;
      end
      case (state)
        S_RD: begin
          rsp_data0 <= regReadData0;
          rsp_data1 <= regReadData1;
        end
        S_WR:    rsp_data0 <= data_q;
        S_CP_RD: rsp_data0 <= regReadData0;
        S_CLR:   if (clr_cnt != LAST_IDX) clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
        S_RESP:  if (rsp_ready) rsp_err <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
